// File: rtl/pifo_level_ram.sv
// One level of PIFO node storage: a two-slot entry per address, swept to the
// empty entry after every reset, with a 1-cycle registered read and write-first bypass.
module pifo_level_ram #(
  parameter  int PTW = 16,
  parameter  int MTW = 32,
  parameter  int CTW = 10,
  parameter  int ADW = 20,
  parameter  int DLG = 8,
  localparam int EW  = 2 * (CTW + MTW + PTW)
) (
  input  logic           i_clk,
  input  logic           i_arst_n,
  input  logic           i_read,
  input  logic [ADW-1:0] i_read_addr,
  output logic [EW-1:0]  o_read_data,
  input  logic           i_write,
  input  logic [ADW-1:0] i_write_addr,
  input  logic [EW-1:0]  i_write_data,
  output logic           o_init_done,
  output logic           o_addr_err,
  input  logic           i_err_clr
);

  localparam int DEPTH = 1 << DLG;
  localparam int SW    = CTW + MTW + PTW;
  localparam logic [SW-1:0] EMPTY_SLOT  = {{CTW{1'b0}}, {MTW{1'b0}}, {PTW{1'b1}}};
  localparam logic [EW-1:0] EMPTY_ENTRY = {EMPTY_SLOT, EMPTY_SLOT};

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t         state_q;
  logic [DLG-1:0] sweep_cnt_q;
  logic           init_done_q;

  logic [EW-1:0]  mem [DEPTH];
  logic [EW-1:0]  ram_rd_q;
  logic [EW-1:0]  ovr_data_q;
  logic           use_ram_q;
  logic [DLG-1:0] held_addr_q;
  logic           held_valid_q;
  logic           addr_err_q;

  logic           rd_in_range;
  logic           wr_in_range;
  logic           running;
  logic           rd_fire;
  logic           wr_fire;
  logic           err_set;
  logic [DLG-1:0] rd_addr;
  logic [DLG-1:0] wr_addr;
  logic           mem_we;
  logic [DLG-1:0] mem_waddr;
  logic [EW-1:0]  mem_wdata;

  generate
    if (DLG < ADW) begin : g_range
      assign rd_in_range = ~|i_read_addr[ADW-1:DLG];
      assign wr_in_range = ~|i_write_addr[ADW-1:DLG];
    end else begin : g_full
      assign rd_in_range = 1'b1;
      assign wr_in_range = 1'b1;
    end
  endgenerate

  assign rd_addr = i_read_addr[DLG-1:0];
  assign wr_addr = i_write_addr[DLG-1:0];
  assign running = (state_q == ST_RUN);
  assign rd_fire = running & i_read;
  assign wr_fire = running & i_write & wr_in_range;
  assign err_set = running & ((i_read & ~rd_in_range) | (i_write & ~wr_in_range));

  // The sweep owns the write port until RUN; node writes are dropped meanwhile.
  assign mem_we    = ~running | wr_fire;
  assign mem_waddr = running ? wr_addr : sweep_cnt_q;
  assign mem_wdata = running ? i_write_data : EMPTY_ENTRY;

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (rd_fire) begin
      ram_rd_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q     <= ST_INIT;
      sweep_cnt_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          sweep_cnt_q <= sweep_cnt_q + 1'b1;
          if (sweep_cnt_q == {DLG{1'b1}}) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          state_q     <= ST_RUN;
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_INIT;
          sweep_cnt_q <= '0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Output is either the raw RAM register or an override (bypass, held update, empty).
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      use_ram_q    <= 1'b0;
      ovr_data_q   <= EMPTY_ENTRY;
      held_addr_q  <= '0;
      held_valid_q <= 1'b0;
    end else if (rd_fire) begin
      held_addr_q <= rd_addr;
      if (!rd_in_range) begin
        use_ram_q    <= 1'b0;
        ovr_data_q   <= EMPTY_ENTRY;
        held_valid_q <= 1'b0;
      end else if (wr_fire && (wr_addr == rd_addr)) begin
        use_ram_q    <= 1'b0;
        ovr_data_q   <= i_write_data;
        held_valid_q <= 1'b1;
      end else begin
        use_ram_q    <= 1'b1;
        held_valid_q <= 1'b1;
      end
    end else if (wr_fire && held_valid_q && (wr_addr == held_addr_q)) begin
      use_ram_q  <= 1'b0;
      ovr_data_q <= i_write_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= err_set | (addr_err_q & ~i_err_clr);
    end
  end

  assign o_read_data = use_ram_q ? ram_rd_q : ovr_data_q;
  assign o_init_done = init_done_q;
  assign o_addr_err  = addr_err_q;

endmodule

// File: tb/tb_pifo_level_ram.sv
// Directed bench for pifo_level_ram: a DLG=3 instance for sweep timing and a
// DLG=8 instance for access, bypass, held-data and range-error behaviour.
module tb_pifo_level_ram;

  localparam int PTW = 16;
  localparam int MTW = 32;
  localparam int CTW = 10;
  localparam int ADW = 20;
  localparam int SW  = CTW + MTW + PTW;
  localparam int EW  = 2 * SW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rd = 1'b0;
  logic [ADW-1:0] rd_addr = '0;
  logic           wr = 1'b0;
  logic [ADW-1:0] wr_addr = '0;
  logic [EW-1:0]  wr_data = '0;
  logic           err_clr = 1'b0;

  logic [EW-1:0]  rdata_s, rdata_b;
  logic           done_s, done_b, err_s, err_b;

  logic [SW-1:0]  empty_slot;
  logic [EW-1:0]  empty_e;
  logic [EW-1:0]  pat_a5, val_x, val_y, val_z, val_w, val_v;
  logic [7:0]     a5_byte;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pifo_level_ram #(.PTW(PTW), .MTW(MTW), .CTW(CTW), .ADW(ADW), .DLG(3)) dut_s (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_read(rd), .i_read_addr(rd_addr), .o_read_data(rdata_s),
    .i_write(wr), .i_write_addr(wr_addr), .i_write_data(wr_data),
    .o_init_done(done_s), .o_addr_err(err_s), .i_err_clr(err_clr)
  );

  pifo_level_ram #(.PTW(PTW), .MTW(MTW), .CTW(CTW), .ADW(ADW), .DLG(8)) dut_b (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_read(rd), .i_read_addr(rd_addr), .o_read_data(rdata_b),
    .i_write(wr), .i_write_addr(wr_addr), .i_write_data(wr_data),
    .o_init_done(done_b), .o_addr_err(err_b), .i_err_clr(err_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n, ns, nb;
    rst_n = 1'b0;
    step();
    checks++;
    if (done_s !== 1'b0 || done_b !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%b%b exp=00", done_s, done_b);
    end
    checks++;
    if (err_s !== 1'b0 || err_b !== 1'b0) begin
      failures++; $display("FAIL reset_err got=%b%b exp=00", err_s, err_b);
    end
    checks++;
    if (rdata_s !== empty_e || rdata_b !== empty_e) begin
      failures++; $display("FAIL reset_rdata got=%h exp=%h", rdata_b, empty_e);
    end
    rst_n = 1'b1;
    ns = 0; nb = 0;
    for (n = 1; n <= 300; n++) begin
      step();
      if (done_s && ns == 0) ns = n;
      if (done_b && nb == 0) nb = n;
      if (nb != 0) break;
    end
    checks++;
    if (ns !== 8) begin
      failures++; $display("FAIL sweep_len_dlg3 got=%0d exp=8", ns);
    end
    checks++;
    if (nb !== 256) begin
      failures++; $display("FAIL sweep_len_dlg8 got=%0d exp=256", nb);
    end
    $display("txn reset+sweep: dlg3 done after %0d, dlg8 done after %0d", ns, nb);
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 8; a++) begin
      rd = 1'b1; rd_addr = ADW'(a);
      step();
      rd = 1'b0;
      checks++;
      if (rdata_s !== empty_e) begin
        failures++; $display("FAIL sweep_read_%0d got=%h exp=%h", a, rdata_s, empty_e);
      end
      $display("txn sweep read addr %0d -> %h", a, rdata_s);
    end
  endtask

  task automatic test_basic();
    wr = 1'b1; wr_addr = 20'd5; wr_data = pat_a5;
    step();
    wr = 1'b0; rd = 1'b1; rd_addr = 20'd5;
    step();
    rd = 1'b0;
    checks++;
    if (rdata_b !== pat_a5) begin
      failures++; $display("FAIL basic_rw got=%h exp=%h", rdata_b, pat_a5);
    end
    step(); step();
    checks++;
    if (rdata_b !== pat_a5) begin
      failures++; $display("FAIL basic_hold got=%h exp=%h", rdata_b, pat_a5);
    end
    $display("txn basic write/read addr 5 -> %h", rdata_b);
  endtask

  task automatic test_bypass();
    wr = 1'b1; wr_addr = 20'd3; wr_data = val_x;
    step();
    wr_data = val_y; rd = 1'b1; rd_addr = 20'd3;
    step();
    wr = 1'b0; rd = 1'b0;
    checks++;
    if (rdata_b !== val_y) begin
      failures++; $display("FAIL bypass got=%h exp=%h", rdata_b, val_y);
    end
    rd = 1'b1; rd_addr = 20'd3;
    step();
    rd = 1'b0;
    checks++;
    if (rdata_b !== val_y) begin
      failures++; $display("FAIL bypass_stored got=%h exp=%h", rdata_b, val_y);
    end
    $display("txn bypass addr 3 -> %h", rdata_b);
  endtask

  task automatic test_held();
    wr = 1'b1; wr_addr = 20'd4; wr_data = val_x;
    step();
    wr = 1'b0; rd = 1'b1; rd_addr = 20'd4;
    step();
    rd = 1'b0;
    checks++;
    if (rdata_b !== val_x) begin
      failures++; $display("FAIL held_read got=%h exp=%h", rdata_b, val_x);
    end
    step(); step();
    checks++;
    if (rdata_b !== val_x) begin
      failures++; $display("FAIL held_idle got=%h exp=%h", rdata_b, val_x);
    end
    wr = 1'b1; wr_addr = 20'd4; wr_data = val_y;
    step();
    wr = 1'b0;
    checks++;
    if (rdata_b !== val_y) begin
      failures++; $display("FAIL held_update got=%h exp=%h", rdata_b, val_y);
    end
    wr = 1'b1; wr_addr = 20'd6; wr_data = val_z;
    step();
    wr = 1'b0;
    checks++;
    if (rdata_b !== val_y) begin
      failures++; $display("FAIL held_other_addr got=%h exp=%h", rdata_b, val_y);
    end
    $display("txn held update addr 4 -> %h", rdata_b);
  endtask

  task automatic test_range();
    wr = 1'b1; wr_addr = 20'h000; wr_data = val_w;
    step();
    wr_addr = 20'h100; wr_data = val_z;
    step();
    wr = 1'b0;
    checks++;
    if (err_b !== 1'b1) begin
      failures++; $display("FAIL range_wr_err got=%b exp=1", err_b);
    end
    rd = 1'b1; rd_addr = 20'h000;
    step();
    rd = 1'b0;
    checks++;
    if (rdata_b !== val_w) begin
      failures++; $display("FAIL range_addr0_intact got=%h exp=%h", rdata_b, val_w);
    end
    checks++;
    if (err_b !== 1'b1) begin
      failures++; $display("FAIL range_err_sticky got=%b exp=1", err_b);
    end
    err_clr = 1'b1; rd = 1'b1; rd_addr = 20'h100;
    step();
    err_clr = 1'b0; rd = 1'b0;
    checks++;
    if (err_b !== 1'b1) begin
      failures++; $display("FAIL range_set_wins got=%b exp=1", err_b);
    end
    checks++;
    if (rdata_b !== empty_e) begin
      failures++; $display("FAIL range_rd_empty got=%h exp=%h", rdata_b, empty_e);
    end
    wr = 1'b1; wr_addr = 20'h000; wr_data = val_v;
    step();
    wr = 1'b0;
    checks++;
    if (rdata_b !== empty_e) begin
      failures++; $display("FAIL range_empty_not_held got=%h exp=%h", rdata_b, empty_e);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (err_b !== 1'b0) begin
      failures++; $display("FAIL range_clear got=%b exp=0", err_b);
    end
    step();
    checks++;
    if (err_b !== 1'b0) begin
      failures++; $display("FAIL range_stays_clear got=%b exp=0", err_b);
    end
    $display("txn range error set/clear, err=%b", err_b);
  endtask

  task automatic test_mid_sweep();
    int n;
    rd = 1'b1; rd_addr = 20'h80000;
    step();
    rd = 1'b0;
    checks++;
    if (err_b !== 1'b1) begin
      failures++; $display("FAIL pre_reset_err got=%b exp=1", err_b);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (err_b !== 1'b0 || done_b !== 1'b0 || rdata_b !== empty_e) begin
      failures++; $display("FAIL async_reset got=err%b done%b data%h exp=err0 done0 data%h",
                           err_b, done_b, rdata_b, empty_e);
    end
    step();
    rst_n = 1'b1;
    wr = 1'b1; wr_addr = 20'd2; wr_data = val_x;
    for (int i = 0; i < 5; i++) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (done_s !== 1'b0 || rdata_s !== empty_e) begin
      failures++; $display("FAIL mid_sweep_reset got=done%b data%h exp=done0 data%h",
                           done_s, rdata_s, empty_e);
    end
    step();
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done_s) begin
        n = i;
        break;
      end
    end
    wr = 1'b0;
    checks++;
    if (n !== 8) begin
      failures++; $display("FAIL resweep_len got=%0d exp=8", n);
    end
    rd = 1'b1; rd_addr = 20'd2;
    step();
    rd = 1'b0;
    checks++;
    if (rdata_s !== empty_e) begin
      failures++; $display("FAIL init_write_ignored got=%h exp=%h", rdata_s, empty_e);
    end
    $display("txn mid-sweep reset: resweep took %0d cycles", n);
  endtask

  initial begin
    empty_slot = {{CTW{1'b0}}, {MTW{1'b0}}, {PTW{1'b1}}};
    empty_e    = {empty_slot, empty_slot};
    a5_byte    = 8'hA5;
    for (int i = 0; i < EW; i++) pat_a5[i] = a5_byte[i % 8];
    val_x = '0; val_x[63:0] = 64'h1111_2222_3333_4444; val_x[115:64] = 52'hA_BBBB_CCCC_DDDD;
    val_y = '0; val_y[63:0] = 64'h5555_6666_7777_8888; val_y[115:64] = 52'h9_0000_1234_5678;
    val_z = '0; val_z[63:0] = 64'hDEAD_BEEF_0BAD_F00D;
    val_w = '0; val_w[63:0] = 64'h0000_0000_CAFE_0001; val_w[115:100] = 16'h8001;
    val_v = '0; val_v[63:0] = 64'h0F0F_0F0F_0F0F_0F0F;

    test_reset();
    test_sweep();
    test_basic();
    test_bypass();
    test_held();
    test_range();
    test_mid_sweep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
